// File: rtl/boot_copy_engine.sv
// Boot copy engine: copies len words from the boot ROM to the destination
// memory one word at a time, then raises a sticky core fetch enable.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i, len_i       copy request and word count (sampled on accept)
//   rom_*                single-outstanding ROM read port (data next cycle)
//   mem_*                destination write port, req/gnt handshake
//   busy_o, done_o       copy in progress / copy completed (levels)
//   error_o              last start rejected, len_i > NUM_WORDS (level)
//   fetch_en_o           set on first completion, held until reset
//   checksum_o           running modular sum of copied words
module boot_copy_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 1024,
    parameter logic [31:0] DST_BASE   = 32'h0000_1000,
    parameter int unsigned DST_AW     = 32,
    localparam int unsigned AW = $clog2(NUM_WORDS),
    localparam int unsigned BW = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [AW:0]           len_i,
    output logic                  rom_req_o,
    output logic                  rom_we_o,
    output logic [AW-1:0]         rom_addr_o,
    output logic [BW-1:0]         rom_be_o,
    input  logic [DATA_WIDTH-1:0] rom_rdata_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic                  mem_we_o,
    output logic [DST_AW-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [BW-1:0]         mem_be_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic                  fetch_en_o,
    output logic [DATA_WIDTH-1:0] checksum_o
);

    localparam int unsigned LW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [LW-1:0]   len_q;
    logic            go;
    logic            bad_len;
    logic            last;
    logic [DST_AW-1:0] wr_addr;

    assign rom_we_o = 1'b0;
    assign rom_be_o = '1;
    assign mem_we_o = mem_req_o;
    assign mem_be_o = '1;

    assign bad_len = len_i > LW'(NUM_WORDS);
    assign last    = ({1'b0, idx_q} + LW'(1)) == len_q;
    assign wr_addr = DST_AW'(DST_BASE)
                   + DST_AW'(idx_q) * DST_AW'(BW);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        go        = 1'b0;
        rom_req_o = 1'b0;
        mem_req_o = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                done_o = (state_q == DONE);
                go     = start_i;
                if (start_i) begin
                    if (bad_len) begin
                        state_d = IDLE;
                    end else if (len_i == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD;
                        idx_d   = '0;
                    end
                end
            end
            RD: begin
                rom_req_o = 1'b1;
                busy_o    = 1'b1;
                state_d   = CAP;
            end
            CAP: begin
                busy_o  = 1'b1;
                state_d = WR;
            end
            WR: begin
                mem_req_o = 1'b1;
                busy_o    = 1'b1;
                if (mem_gnt_i) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            error_o     <= 1'b0;
            fetch_en_o  <= 1'b0;
            checksum_o  <= '0;
            rom_addr_o  <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (go) begin
                error_o <= bad_len;
                if (!bad_len) begin
                    checksum_o <= '0;
                    len_q      <= len_i;
                end
            end
            // ROM address only moves on entry to RD, so it holds elsewhere
            if (state_d == RD) begin
                rom_addr_o <= idx_d;
            end
            // Captured word doubles as the write buffer seen in WR
            if (state_q == CAP) begin
                mem_wdata_o <= rom_rdata_i;
                mem_addr_o  <= wr_addr;
                checksum_o  <= checksum_o + rom_rdata_i;
            end
            if (state_d == DONE) begin
                fetch_en_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_boot_copy_engine.sv
// Testbench for boot_copy_engine: a transaction-level model predicts the
// write stream, status levels and checksum; directed tests pin it.
module tb_boot_copy_engine;

    localparam int DW = 32;
    localparam int NW = 1024;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [AW:0]   len_i = '0;
    logic          rom_req_o;
    logic          rom_we_o;
    logic [AW-1:0] rom_addr_o;
    logic [3:0]    rom_be_o;
    logic [DW-1:0] rom_rdata_i = '0;
    logic          mem_req_o;
    logic          mem_gnt_i = 1'b1;
    logic          mem_we_o;
    logic [31:0]   mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [3:0]    mem_be_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic          fetch_en_o;
    logic [DW-1:0] checksum_o;

    boot_copy_engine dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .len_i       (len_i),
        .rom_req_o   (rom_req_o),
        .rom_we_o    (rom_we_o),
        .rom_addr_o  (rom_addr_o),
        .rom_be_o    (rom_be_o),
        .rom_rdata_i (rom_rdata_i),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .fetch_en_o  (fetch_en_o),
        .checksum_o  (checksum_o)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [NW];

    always @(posedge clk) begin
        if (rom_req_o) rom_rdata_i <= rom[rom_addr_o];
    end

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         log_q[$];
    int          runs_q[$];
    int          m_len = 0;
    bit          m_done = 0;
    bit          m_err = 0;
    bit          m_fetch = 0;
    logic [31:0] m_cksum = '0;
    int          rom_reads = 0;
    int          run = 0;
    bit          stall_prev = 0;
    logic [31:0] prev_a = '0;
    logic [31:0] prev_d = '0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: an accepted start enqueues the whole expected write stream
    always @(posedge clk) begin
        if (rst_ni && start_i && exp_q.size() == 0) begin
            if (int'(len_i) > NW) begin
                m_err  = 1;
                m_done = 0;
            end else begin
                m_err   = 0;
                m_cksum = '0;
                m_len   = int'(len_i);
                m_done  = (len_i == 0);
                if (len_i == 0) m_fetch = 1;
                for (int i = 0; i < int'(len_i); i++) begin
                    exp_q.push_back('{a: 32'h1000 + 32'(4 * i),
                                      d: rom[i]});
                    m_cksum = m_cksum + rom[i];
                end
            end
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete();
            m_done     = 0;
            m_err      = 0;
            m_fetch    = 0;
            m_cksum    = '0;
            stall_prev = 0;
            run        = 0;
        end
        chk("busy", 32'(busy_o), 32'(exp_q.size() != 0));
        chk("done", 32'(done_o), 32'(m_done));
        chk("error", 32'(error_o), 32'(m_err));
        chk("fetch", 32'(fetch_en_o), 32'(m_fetch));
        if (exp_q.size() == 0)
            chk("cksum", checksum_o, m_cksum);
        chk("excl", 32'(rom_req_o && mem_req_o), 32'd0);
        chk("rom_we", 32'(rom_we_o), 32'd0);
        chk("rom_be", 32'(rom_be_o), 32'hF);
        chk("mem_be", 32'(mem_be_o), 32'hF);
        chk("mem_we", 32'(mem_we_o), 32'(mem_req_o));
        if (rom_req_o) begin
            rom_reads++;
            if (exp_q.size() == 0)
                chk("rom_idle", 32'(rom_req_o), 32'd0);
            else
                chk("rom_addr", 32'(rom_addr_o),
                    32'(m_len - exp_q.size()));
        end
        if (stall_prev) begin
            chk("stall_req", 32'(mem_req_o), 32'd1);
            chk("stall_addr", mem_addr_o, prev_a);
            chk("stall_data", mem_wdata_o, prev_d);
        end
        if (mem_req_o) begin
            if (exp_q.size() == 0) begin
                chk("mem_idle", 32'(mem_req_o), 32'd0);
            end else begin
                run++;
                if (mem_gnt_i) begin
                    chk("wr_addr", mem_addr_o, exp_q[0].a);
                    chk("wr_data", mem_wdata_o, exp_q[0].d);
                    log_q.push_back('{a: mem_addr_o, d: mem_wdata_o});
                    void'(exp_q.pop_front());
                    runs_q.push_back(run);
                    run = 0;
                    if (exp_q.size() == 0) begin
                        m_done  = 1;
                        m_fetch = 1;
                    end
                end
            end
        end
        stall_prev = mem_req_o && !mem_gnt_i;
        prev_a     = mem_addr_o;
        prev_d     = mem_wdata_o;
    end

    task automatic do_start(input int len);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        len_i   = (AW + 1)'(len);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done_o && cyc < 200);
        chk("done_timeout", 32'(done_o), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_err"}, 32'(error_o), 32'd0);
        chk({tag, "_fetch"}, 32'(fetch_en_o), 32'd0);
        chk({tag, "_romreq"}, 32'(rom_req_o), 32'd0);
        chk({tag, "_memreq"}, 32'(mem_req_o), 32'd0);
        chk({tag, "_cksum"}, checksum_o, 32'd0);
        chk({tag, "_romaddr"}, 32'(rom_addr_o), 32'd0);
        chk({tag, "_memaddr"}, mem_addr_o, 32'd0);
        chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
    endtask

    logic [31:0] ea [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    logic [31:0] ed [4] = '{32'd1, 32'd2, 32'd3, 32'd4};

    initial begin
        int cyc;
        int n;
        for (int i = 0; i < NW; i++) rom[i] = 32'(i + 1);
        #1;
        chk_reset_vals("rst");
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;

        // Four-word copy with grant tied high
        mem_gnt_i = 1'b1;
        log_q.delete();
        do_start(4);
        wait_done(cyc);
        chk("t1_done_cycle", 32'(cyc), 32'd13);
        chk("t1_writes", 32'(log_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < log_q.size(); k++) begin
            chk("t1_addr", log_q[k].a, ea[k]);
            chk("t1_data", log_q[k].d, ed[k]);
        end
        chk("t1_cksum", checksum_o, 32'd10);
        chk("t1_fetch", 32'(fetch_en_o), 32'd1);

        // Grant withheld for 5 cycles on word 0
        log_q.delete();
        runs_q.delete();
        rom_reads = 0;
        mem_gnt_i = 1'b0;
        do_start(2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req_o && n < 10);
        chk("t2_req_seen", 32'(mem_req_o), 32'd1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 mem_gnt_i = 1'b1;
        wait_done(cyc);
        chk("t2_run", 32'(runs_q.size() > 0 ? runs_q[0] : 0), 32'd6);
        chk("t2_writes", 32'(log_q.size()), 32'd2);
        chk("t2_rom_reads", 32'(rom_reads), 32'd2);

        // Oversize length, then zero length
        log_q.delete();
        rom_reads = 0;
        do_start(1025);
        @(negedge clk);
        chk("t3_err", 32'(error_o), 32'd1);
        chk("t3_busy", 32'(busy_o), 32'd0);
        chk("t3_done", 32'(done_o), 32'd0);
        repeat (3) @(negedge clk);
        chk("t3_rom_reads", 32'(rom_reads), 32'd0);
        chk("t3_writes", 32'(log_q.size()), 32'd0);
        do_start(0);
        @(negedge clk);
        chk("t3_err0", 32'(error_o), 32'd0);
        chk("t3_done0", 32'(done_o), 32'd1);
        chk("t3_cksum0", checksum_o, 32'd0);

        // Start pulsed while busy is ignored; restart from DONE
        log_q.delete();
        do_start(3);
        repeat (2) @(posedge clk);
        #1;
        start_i = 1'b1;
        len_i   = 11'd5;
        @(posedge clk);
        #1 start_i = 1'b0;
        wait_done(cyc);
        chk("t4_writes", 32'(log_q.size()), 32'd3);
        chk("t4_cksum", checksum_o, 32'd6);
        do_start(1);
        @(negedge clk);
        chk("t4_done_drop", 32'(done_o), 32'd0);
        chk("t4_fetch_hold", 32'(fetch_en_o), 32'd1);
        wait_done(cyc);
        chk("t4_done_rise", 32'(done_o), 32'd1);
        chk("t4_fetch", 32'(fetch_en_o), 32'd1);
        chk("t4_cksum1", checksum_o, 32'd1);

        // Reset during the write of word 2 of 8
        do_start(8);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_req_o && mem_addr_o == 32'h1008) && n < 50);
        chk("t5_reach_w2", mem_addr_o, 32'h1008);
        #1 rst_ni = 1'b0;
        #1;
        chk_reset_vals("t5");
        @(posedge clk);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        rom_reads = 0;
        log_q.delete();
        repeat (10) @(negedge clk);
        chk("t5_rom_reads", 32'(rom_reads), 32'd0);
        chk("t5_writes", 32'(log_q.size()), 32'd0);
        do_start(1);
        wait_done(cyc);
        chk("t5_restart", 32'(log_q.size()), 32'd1);

        // Checksum wrap-around
        rom[0] = 32'hFFFF_FFFF;
        rom[1] = 32'hFFFF_FFFF;
        do_start(2);
        wait_done(cyc);
        chk("t6_cksum", checksum_o, 32'hFFFF_FFFE);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
